snake_head_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 21 ++
 rtl/snake_history.sv | 43 ++++
 rtl/snake_head_ctrl.sv | 135 +++++++++++++
 tb/tb_snake_head_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake head controller
package snake_pkg;

  localparam int COORD_W   = 5;
  localparam int HIST_W    = 2 * COORD_W;
  localparam int START_I   = 10;
  localparam int START_J   = 7;
  localparam int START_LEN = 3;

  // (31,31) is outside any legal grid, so an unused history slot never matches
  localparam logic [HIST_W-1:0] HIST_EMPTY = '1;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a == UP    && b == DOWN) || (a == DOWN  && b == UP) ||
           (a == LEFT  && b == RIGHT) || (a == RIGHT && b == LEFT);
  endfunction

endpackage

// File: rtl/snake_history.sv
// rtl/snake_history.sv - body position shift register with masked parallel hit detect
module snake_history
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_shift,
  input  logic [HIST_W-1:0] i_entry,
  input  logic [HIST_W-1:0] i_query,
  input  logic [15:0]       i_limit,
  output logic              o_hit
);

  logic [HIST_W-1:0] r_hist [MAX_LEN];
  logic [MAX_LEN-1:0] w_hit_vec;

  function automatic logic [HIST_W-1:0] seed(input int k);
    if (k < START_LEN)
      return {COORD_W'(START_I), COORD_W'(START_J - k)};
    return HIST_EMPTY;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_LEN; k++) r_hist[k] <= seed(k);
    end else if (i_shift) begin
      r_hist[0] <= i_entry;
      for (int k = 1; k < MAX_LEN; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  // Only entries up to i_limit still belong to the body after this tick
  always_comb begin
    w_hit_vec = '0;
    for (int k = 0; k < MAX_LEN; k++)
      w_hit_vec[k] = (r_hist[k] == i_query) && (16'(k) <= i_limit);
  end

  assign o_hit = |w_hit_vec;

endmodule

// File: rtl/snake_head_ctrl.sv
// rtl/snake_head_ctrl.sv - snake head FSM, direction latch and length; SNAKE_WRAP_EN enables wraparound
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sys,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic [COORD_W-1:0] food_i,
  input  logic [COORD_W-1:0] food_j,
  output logic [COORD_W-1:0] i_head,
  output logic [COORD_W-1:0] j_head,
  output logic [15:0]        length,
  output logic               gameOver,
  output logic               ate
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t r_state, w_state_nxt;
  dir_t   r_dir, r_last_dir, w_btn_dir, w_ref_dir;
  logic [COORD_W-1:0] r_i, r_j, w_ni, w_nj;
  logic [15:0] r_len, w_limit;
  logic r_ate;
  logic w_press, w_move, w_dir_ok, w_edge, w_wall, w_eat, w_hit, w_legal;

  assign w_press = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    w_btn_dir = RIGHT;
    if      (btn_up)   w_btn_dir = UP;
    else if (btn_down) w_btn_dir = DOWN;
    else if (btn_left) w_btn_dir = LEFT;
  end

  // A press coinciding with a tick is judged against the move being made now
  assign w_move    = (r_state == RUN) && sys;
  assign w_ref_dir = w_move ? r_dir : r_last_dir;
  assign w_dir_ok  = w_press && !is_reverse(w_btn_dir, w_ref_dir);

  always_comb begin
    w_ni   = r_i;
    w_nj   = r_j;
    w_edge = 1'b0;
    case (r_dir)
      UP: begin
        if (r_i == '0) begin w_edge = 1'b1; w_ni = COORD_W'(ROWS - 1); end
        else w_ni = r_i - COORD_W'(1);
      end
      DOWN: begin
        if (r_i == COORD_W'(ROWS - 1)) begin w_edge = 1'b1; w_ni = '0; end
        else w_ni = r_i + COORD_W'(1);
      end
      LEFT: begin
        if (r_j == '0) begin w_edge = 1'b1; w_nj = COORD_W'(COLS - 1); end
        else w_nj = r_j - COORD_W'(1);
      end
      default: begin
        if (r_j == COORD_W'(COLS - 1)) begin w_edge = 1'b1; w_nj = '0; end
        else w_nj = r_j + COORD_W'(1);
      end
    endcase
  end

  assign w_wall  = w_edge && !WRAP_EN;
  assign w_eat   = ({w_ni, w_nj} == {food_i, food_j});
  // When eating, the tail stays put, so it remains a collision target
  assign w_limit = w_eat ? (r_len - 16'd1) : (r_len - 16'd2);
  assign w_legal = w_move && !w_wall && !w_hit;

  snake_history #(.MAX_LEN(MAX_LEN)) u_history (
    .clk     (clk),
    .reset   (reset),
    .i_shift (w_legal),
    .i_entry ({w_ni, w_nj}),
    .i_query ({w_ni, w_nj}),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_press) w_state_nxt = RUN;
      RUN:     if (w_move && (w_wall || w_hit)) w_state_nxt = DEAD;
      default: w_state_nxt = DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir      <= RIGHT;
      r_last_dir <= RIGHT;
      r_i        <= COORD_W'(START_I);
      r_j        <= COORD_W'(START_J);
      r_len      <= 16'(START_LEN);
      r_ate      <= 1'b0;
    end else begin
      r_ate <= 1'b0;
      if (r_state != DEAD) begin
        if (w_dir_ok) r_dir <= w_btn_dir;
        if (w_legal) begin
          r_i        <= w_ni;
          r_j        <= w_nj;
          r_last_dir <= r_dir;
          r_ate      <= w_eat;
          if (w_eat && r_len < 16'(MAX_LEN)) r_len <= r_len + 16'd1;
        end
      end
    end
  end

  assign i_head   = r_i;
  assign j_head   = r_j;
  assign length   = r_len;
  assign gameOver = (r_state == DEAD);
  assign ate      = r_ate;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// tb/tb_snake_head_ctrl.sv - self-checking bench for snake_head_ctrl with a behavioural game model
module tb_snake_head_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1, sys = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [4:0] food_i = '0, food_j = '0;
  logic [4:0] i_head, j_head;
  logic [15:0] length;
  logic gameOver, ate;

  int checks = 0;
  int failures = 0;

  localparam bit [3:0] B_NO = 4'b0000, B_UP = 4'b1000, B_DN = 4'b0100,
                       B_LT = 4'b0010, B_RT = 4'b0001;

  snake_head_ctrl dut (
    .clk(clk), .reset(reset), .sys(sys),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .food_i(food_i), .food_j(food_j),
    .i_head(i_head), .j_head(j_head), .length(length),
    .gameOver(gameOver), .ate(ate)
  );

  always #5 clk = ~clk;

  // Game model: body is a list of cells, newest first; directions 0=up 1=down 2=left 3=right
  int m_i, m_j, m_len, m_dir, m_last;
  bit m_run, m_dead, m_ate;
  int body[$];
  int di[4] = '{-1, 1, 0, 0};
  int dj[4] = '{0, 0, -1, 1};

  task automatic model_step(input bit s, input bit [3:0] b, input int fi, input int fj, input bit rst);
    int ni, nj, chosen, refd, lim;
    bit moving, outside, eat, hit, new_ate;
    if (rst) begin
      m_i = 10; m_j = 7; m_len = 3; m_dir = 3; m_last = 3;
      m_run = 0; m_dead = 0; m_ate = 0;
      body = {};
      for (int k = 0; k < 32; k++) body.push_back(k < 3 ? (10 * 32 + 7 - k) : (31 * 32 + 31));
      return;
    end
    new_ate = 0;
    if (!m_dead) begin
      chosen = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
      moving = m_run && s;
      refd = moving ? m_dir : m_last;
      if (moving) begin
        ni = m_i + di[m_dir];
        nj = m_j + dj[m_dir];
        outside = (ni < 0) || (ni > 15) || (nj < 0) || (nj > 15);
`ifdef SNAKE_WRAP_EN
        ni = (ni + 16) % 16;
        nj = (nj + 16) % 16;
        outside = 0;
`endif
        eat = (ni == fi) && (nj == fj);
        lim = eat ? m_len - 1 : m_len - 2;
        hit = 0;
        for (int k = 0; k <= lim; k++) if (body[k] == ni * 32 + nj) hit = 1;
        if (outside || hit) m_dead = 1;
        else begin
          body.push_front(ni * 32 + nj);
          void'(body.pop_back());
          m_i = ni; m_j = nj; m_last = m_dir; new_ate = eat;
          if (eat && m_len < 32) m_len++;
        end
      end
      if (b != 0 && chosen != (refd ^ 1)) m_dir = chosen;
      if (!m_run && b != 0) m_run = 1;
    end
    m_ate = new_ate;
  endtask

  task automatic drive_cycle(input bit s, input bit [3:0] b, input int fi, input int fj, input bit rst);
    sys = s; reset = rst;
    {btn_up, btn_down, btn_left, btn_right} = b;
    food_i = 5'(fi); food_j = 5'(fj);
    @(posedge clk);
    model_step(s, b, fi, fj, rst);
    #1;
  endtask

  task automatic do_reset();
    drive_cycle(0, B_NO, 0, 0, 1);
    drive_cycle(0, B_NO, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd7}) begin
      failures++; $display("FAIL reset_head got=(%0d,%0d) exp=(10,7)", i_head, j_head);
    end
    checks++;
    if (length !== 16'd3 || gameOver !== 1'b0 || ate !== 1'b0) begin
      failures++; $display("FAIL reset_state got len=%0d go=%0b ate=%0b exp len=3 go=0 ate=0", length, gameOver, ate);
    end
    drive_cycle(1, B_NO, 10, 8, 0);
    drive_cycle(1, B_NO, 10, 8, 0);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd7} || ate !== 1'b0) begin
      failures++; $display("FAIL idle_ignores_sys got=(%0d,%0d) ate=%0b exp=(10,7) ate=0", i_head, j_head, ate);
    end
  endtask

  task automatic test_basic_run();
    do_reset();
    drive_cycle(0, B_RT, 0, 0, 0);
    for (int t = 1; t <= 3; t++) begin
      drive_cycle(1, B_NO, 0, 0, 0);
      checks++;
      if ({i_head, j_head} !== {5'd10, 5'(7 + t)} || length !== 16'd3 || gameOver !== 1'b0) begin
        failures++;
        $display("FAIL basic_run_tick%0d got=(%0d,%0d) len=%0d go=%0b exp=(10,%0d) len=3 go=0",
                 t, i_head, j_head, length, gameOver, 7 + t);
      end
    end
  endtask

  task automatic test_reversal();
    do_reset();
    drive_cycle(0, B_RT, 0, 0, 0);
    drive_cycle(0, B_LT, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd8}) begin
      failures++; $display("FAIL reversal_ignored got=(%0d,%0d) exp=(10,8)", i_head, j_head);
    end
    drive_cycle(0, B_UP, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if ({i_head, j_head} !== {5'd9, 5'd8}) begin
      failures++; $display("FAIL turn_up got=(%0d,%0d) exp=(9,8)", i_head, j_head);
    end
    // press in the tick cycle applies only from the next tick
    drive_cycle(1, B_LT, 0, 0, 0);
    checks++;
    if ({i_head, j_head} !== {5'd8, 5'd8}) begin
      failures++; $display("FAIL same_cycle_press got=(%0d,%0d) exp=(8,8)", i_head, j_head);
    end
    drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if ({i_head, j_head} !== {5'd8, 5'd7}) begin
      failures++; $display("FAIL deferred_turn got=(%0d,%0d) exp=(8,7)", i_head, j_head);
    end
  endtask

  task automatic test_eat();
    do_reset();
    drive_cycle(0, B_RT, 10, 8, 0);
    drive_cycle(1, B_NO, 10, 8, 0);
    checks++;
    if (ate !== 1'b1 || length !== 16'd4) begin
      failures++; $display("FAIL eat_pulse got ate=%0b len=%0d exp ate=1 len=4", ate, length);
    end
    drive_cycle(0, B_NO, 10, 8, 0);
    checks++;
    if (ate !== 1'b0 || length !== 16'd4) begin
      failures++; $display("FAIL eat_pulse_end got ate=%0b len=%0d exp ate=0 len=4", ate, length);
    end
  endtask

  task automatic test_wall();
    do_reset();
    drive_cycle(0, B_RT, 0, 0, 0);
    for (int t = 0; t < 8; t++) drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd15}) begin
      failures++; $display("FAIL wall_approach got=(%0d,%0d) exp=(10,15)", i_head, j_head);
    end
    drive_cycle(1, B_NO, 0, 0, 0);
`ifdef SNAKE_WRAP_EN
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd0} || gameOver !== 1'b0) begin
      failures++; $display("FAIL wall_wrap got=(%0d,%0d) go=%0b exp=(10,0) go=0", i_head, j_head, gameOver);
    end
`else
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd15} || gameOver !== 1'b1) begin
      failures++; $display("FAIL wall_death got=(%0d,%0d) go=%0b exp=(10,15) go=1", i_head, j_head, gameOver);
    end
    drive_cycle(1, B_UP, 9, 15, 0);
    drive_cycle(1, B_NO, 9, 15, 0);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd15} || gameOver !== 1'b1 || ate !== 1'b0) begin
      failures++; $display("FAIL dead_frozen got=(%0d,%0d) go=%0b ate=%0b exp=(10,15) go=1 ate=0", i_head, j_head, gameOver, ate);
    end
    drive_cycle(0, B_NO, 0, 0, 1);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd7} || length !== 16'd3 || gameOver !== 1'b0) begin
      failures++; $display("FAIL reset_from_dead got=(%0d,%0d) len=%0d go=%0b exp=(10,7) len=3 go=0", i_head, j_head, length, gameOver);
    end
`endif
  endtask

  task automatic test_self_collision();
    do_reset();
    drive_cycle(0, B_RT, 0, 0, 0);
    drive_cycle(1, B_NO, 10, 8, 0);
    drive_cycle(1, B_NO, 10, 9, 0);
    drive_cycle(0, B_UP, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    drive_cycle(0, B_LT, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    drive_cycle(0, B_DN, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if (length !== 16'd5 || gameOver !== 1'b1 || {i_head, j_head} !== {5'd9, 5'd8}) begin
      failures++; $display("FAIL self_hit got=(%0d,%0d) len=%0d go=%0b exp=(9,8) len=5 go=1", i_head, j_head, length, gameOver);
    end
    do_reset();
    drive_cycle(0, B_RT, 0, 0, 0);
    drive_cycle(1, B_NO, 10, 8, 0);
    drive_cycle(0, B_UP, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    drive_cycle(0, B_LT, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    drive_cycle(0, B_DN, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if (length !== 16'd4 || gameOver !== 1'b0 || {i_head, j_head} !== {5'd10, 5'd7}) begin
      failures++; $display("FAIL tail_vacate got=(%0d,%0d) len=%0d go=%0b exp=(10,7) len=4 go=0", i_head, j_head, length, gameOver);
    end
  endtask

  task automatic test_reset_mid_tick();
    do_reset();
    drive_cycle(0, B_RT, 0, 0, 0);
    drive_cycle(1, B_NO, 0, 0, 0);
    drive_cycle(1, B_UP, 10, 9, 1);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd7} || length !== 16'd3 || gameOver !== 1'b0 || ate !== 1'b0) begin
      failures++; $display("FAIL reset_mid_tick got=(%0d,%0d) len=%0d go=%0b ate=%0b exp=(10,7) len=3 go=0 ate=0",
                           i_head, j_head, length, gameOver, ate);
    end
    drive_cycle(1, B_NO, 0, 0, 0);
    checks++;
    if ({i_head, j_head} !== {5'd10, 5'd7}) begin
      failures++; $display("FAIL reset_to_idle got=(%0d,%0d) exp=(10,7)", i_head, j_head);
    end
  endtask

  task automatic test_random();
    bit s, r;
    bit [3:0] b;
    int fi, fj;
    do_reset();
    for (int n = 0; n < 4000 && failures < 20; n++) begin
      s = ($urandom_range(2) == 0);
      b = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : B_NO;
      if ($urandom_range(1) == 0) begin
        fi = (m_i + di[m_dir]) & 31;
        fj = (m_j + dj[m_dir]) & 31;
      end else begin
        fi = $urandom_range(15);
        fj = $urandom_range(15);
      end
      r = m_dead ? ($urandom_range(3) == 0) : ($urandom_range(200) == 0);
      drive_cycle(s, b, fi, fj, r);
      checks++;
      if (i_head !== 5'(m_i) || j_head !== 5'(m_j) || length !== 16'(m_len) ||
          gameOver !== m_dead || ate !== m_ate) begin
        failures++;
        $display("FAIL random_cycle%0d got=(%0d,%0d) len=%0d go=%0b ate=%0b exp=(%0d,%0d) len=%0d go=%0b ate=%0b",
                 n, i_head, j_head, length, gameOver, ate, m_i, m_j, m_len, m_dead, m_ate);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_reversal();
    test_eat();
    test_wall();
    test_self_collision();
    test_reset_mid_tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
